run_monitor: RTL and testbench

RUN_MONITOR -- requirements
Module: run_monitor

---
 rtl/run_monitor_pkg.sv | 16 +
 rtl/run_monitor_halt_match.sv | 27 ++
 rtl/run_monitor.sv | 119 +++++++++++
 tb/tb_run_monitor.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/run_monitor_pkg.sv
// Shared types and helpers for the run monitor: FSM state encoding and index-width calculation.
package run_monitor_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUN     = 2'd1,
    ST_HALTED  = 2'd2,
    ST_TIMEOUT = 2'd3
  } state_e;

  // Comparator index width; at least one bit even for a single comparator.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/run_monitor_halt_match.sv
// halt_match: NUM_HALT-way PC comparator with lowest-index-wins priority encoder.
module halt_match
  import run_monitor_pkg::*;
#(
  parameter int unsigned PC_W     = 32,
  parameter int unsigned NUM_HALT = 2,
  parameter int unsigned IDX_W    = idx_w(NUM_HALT)
) (
  input  logic [PC_W-1:0]          i_pc,
  input  logic [NUM_HALT*PC_W-1:0] i_halt_addr,
  input  logic [NUM_HALT-1:0]      i_halt_en,
  output logic                     o_match,
  output logic [IDX_W-1:0]         o_idx
);

  always_comb begin
    o_match = 1'b0;
    o_idx   = '0;
    for (int k = 0; k < int'(NUM_HALT); k++) begin
      if (!o_match && i_halt_en[k] && (i_pc == i_halt_addr[k*PC_W +: PC_W])) begin
        o_match = 1'b1;
        o_idx   = IDX_W'(k);
      end
    end
  end

endmodule

// File: rtl/run_monitor.sv
// run_monitor: gates the CPU clock enable, halts on PC match, counts enabled cycles.
// Optional timeout watchdog compiled in with `define RUN_MONITOR_TIMEOUT_EN.
module run_monitor
  import run_monitor_pkg::*;
#(
  parameter int unsigned PC_W     = 32,
  parameter int unsigned NUM_HALT = 2,
  parameter int unsigned CNT_W    = 32,
  parameter int unsigned ANS_W    = 8,
  localparam int unsigned IDX_W   = idx_w(NUM_HALT)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_start,
  input  logic                     i_step_mode,
  input  logic                     i_step,
  input  logic [PC_W-1:0]          i_pc,
  input  logic [NUM_HALT*PC_W-1:0] i_halt_addr,
  input  logic [NUM_HALT-1:0]      i_halt_en,
  input  logic [CNT_W-1:0]         i_timeout,
  input  logic [ANS_W-1:0]         i_answer,
  output logic                     o_cpu_en,
  output logic                     o_terminal,
  output logic                     o_timeout,
  output logic [IDX_W-1:0]         o_halt_idx,
  output logic [CNT_W-1:0]         o_cycles,
  output logic [ANS_W-1:0]         o_answer
);

  state_e           r_state;
  logic             r_terminal;
  logic             r_timeout;
  logic [IDX_W-1:0] r_halt_idx;
  logic [CNT_W-1:0] r_cycles;
  logic [ANS_W-1:0] r_answer;

  logic             w_match;
  logic [IDX_W-1:0] w_idx;
  logic             w_cpu_en;
  logic [CNT_W-1:0] w_cycles_inc;
  logic [CNT_W-1:0] w_cycles_nxt;

  halt_match #(
    .PC_W     (PC_W),
    .NUM_HALT (NUM_HALT),
    .IDX_W    (IDX_W)
  ) u_halt_match (
    .i_pc        (i_pc),
    .i_halt_addr (i_halt_addr),
    .i_halt_en   (i_halt_en),
    .o_match     (w_match),
    .o_idx       (w_idx)
  );

  // Enable is withheld in the match cycle so the CPU never executes the halt address.
  assign w_cpu_en     = (r_state == ST_RUN) && !w_match && (!i_step_mode || i_step);
  assign w_cycles_inc = r_cycles + CNT_W'(1);
  assign w_cycles_nxt = (r_cycles == '1) ? r_cycles : w_cycles_inc;

`ifndef RUN_MONITOR_TIMEOUT_EN
  logic w_unused_timeout;
  assign w_unused_timeout = ^i_timeout;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_terminal <= 1'b0;
      r_timeout  <= 1'b0;
      r_halt_idx <= '0;
      r_cycles   <= '0;
      r_answer   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (i_start) begin
            r_state  <= ST_RUN;
            r_cycles <= '0;
          end
        end
        ST_RUN: begin
          // Match takes priority over a coincident timeout.
          if (w_match) begin
            r_state    <= ST_HALTED;
            r_terminal <= 1'b1;
            r_halt_idx <= w_idx;
            r_answer   <= i_answer;
          end else if (w_cpu_en) begin
            r_cycles <= w_cycles_nxt;
`ifdef RUN_MONITOR_TIMEOUT_EN
            if ((i_timeout != '0) && (w_cycles_inc == i_timeout)) begin
              r_state   <= ST_TIMEOUT;
              r_timeout <= 1'b1;
            end
`endif
          end
        end
        ST_HALTED, ST_TIMEOUT: begin
          // Answer and index stay visible until the next halt.
          if (i_start) begin
            r_state    <= ST_RUN;
            r_terminal <= 1'b0;
            r_timeout  <= 1'b0;
            r_cycles   <= '0;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_cpu_en   = w_cpu_en;
  assign o_terminal = r_terminal;
  assign o_timeout  = r_timeout;
  assign o_halt_idx = r_halt_idx;
  assign o_cycles   = r_cycles;
  assign o_answer   = r_answer;

endmodule

// File: tb/tb_run_monitor.sv
// Directed self-checking bench for run_monitor (default parameters); timeout cases follow RUN_MONITOR_TIMEOUT_EN.
module tb_run_monitor;

  localparam int unsigned PC_W     = 32;
  localparam int unsigned NUM_HALT = 2;
  localparam int unsigned CNT_W    = 32;
  localparam int unsigned ANS_W    = 8;
  localparam int unsigned IDX_W    = 1;

  logic                     clk = 1'b0;
  logic                     rst;
  logic                     i_start;
  logic                     i_step_mode;
  logic                     i_step;
  logic [PC_W-1:0]          i_pc;
  logic [NUM_HALT*PC_W-1:0] i_halt_addr;
  logic [NUM_HALT-1:0]      i_halt_en;
  logic [CNT_W-1:0]         i_timeout;
  logic [ANS_W-1:0]         i_answer;
  logic                     o_cpu_en;
  logic                     o_terminal;
  logic                     o_timeout;
  logic [IDX_W-1:0]         o_halt_idx;
  logic [CNT_W-1:0]         o_cycles;
  logic [ANS_W-1:0]         o_answer;

  int total = 0;
  int bad   = 0;
  logic        pc_auto = 1'b0;
  logic [31:0] watch_pc = 32'hFFFF_FFFF;
  logic        en_at_watch = 1'b1;

  run_monitor #(
    .PC_W(PC_W), .NUM_HALT(NUM_HALT), .CNT_W(CNT_W), .ANS_W(ANS_W)
  ) dut (
    .clk(clk), .rst(rst), .i_start(i_start), .i_step_mode(i_step_mode), .i_step(i_step),
    .i_pc(i_pc), .i_halt_addr(i_halt_addr), .i_halt_en(i_halt_en), .i_timeout(i_timeout),
    .i_answer(i_answer), .o_cpu_en(o_cpu_en), .o_terminal(o_terminal), .o_timeout(o_timeout),
    .o_halt_idx(o_halt_idx), .o_cycles(o_cycles), .o_answer(o_answer)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: sample enable mid-cycle, emulate the CPU advancing PC by 4 on enabled cycles.
  task automatic tick();
    logic en_s;
    @(negedge clk);
    en_s = o_cpu_en;
    if (i_pc == watch_pc) en_at_watch = en_s;
    @(posedge clk);
    #1;
    if (pc_auto && en_s) i_pc = i_pc + 32'd4;
  endtask

  task automatic start_pulse();
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
  endtask

  task automatic run_until_stop(input int max_cycles);
    for (int i = 0; i < max_cycles && !o_terminal && !o_timeout; i++) tick();
  endtask

  initial begin
    rst = 1'b1; i_start = 1'b0; i_step_mode = 1'b0; i_step = 1'b0;
    i_pc = '0; i_halt_addr = '0; i_halt_en = '0; i_timeout = '0; i_answer = '0;
    tick(); tick();
    rst = 1'b0;
    #1;
    chk("rst_cpu_en",   64'(o_cpu_en),   64'd0);
    chk("rst_terminal", 64'(o_terminal), 64'd0);
    chk("rst_timeout",  64'(o_timeout),  64'd0);
    chk("rst_idx",      64'(o_halt_idx), 64'd0);
    chk("rst_cycles",   64'(o_cycles),   64'd0);
    chk("rst_answer",   64'(o_answer),   64'd0);

    // Halt at 0x54 from PC 0: 21 enabled cycles; comparator 1 at 0 is disabled.
    i_halt_addr = {32'h0000_0000, 32'h0000_0054};
    i_halt_en   = 2'b01;
    i_answer    = 8'h11;
    i_pc        = '0;
    pc_auto     = 1'b1;
    watch_pc    = 32'h54;
    start_pulse();
    chk("run_cpu_en", 64'(o_cpu_en), 64'd1);
    run_until_stop(100);
    chk("h54_en_at_match", 64'(en_at_watch), 64'd0);
    chk("h54_terminal",    64'(o_terminal),  64'd1);
    chk("h54_idx",         64'(o_halt_idx),  64'd0);
    chk("h54_cycles",      64'(o_cycles),    64'd21);
    chk("h54_answer",      64'(o_answer),    64'h11);
    chk("h54_pc_held",     64'(i_pc),        64'h54);
    tick();
    chk("halted_sticky",   64'(o_terminal),  64'd1);
    chk("halted_cpu_en",   64'(o_cpu_en),    64'd0);

    // Restart from HALTED: flags and count clear, answer held.
    watch_pc = 32'hFFFF_FFFF;
    i_pc     = 32'h100;
    i_answer = 8'h22;
    start_pulse();
    chk("rs_terminal", 64'(o_terminal), 64'd0);
    chk("rs_cycles",   64'(o_cycles),   64'd0);
    chk("rs_answer",   64'(o_answer),   64'h11);
    chk("rs_cpu_en",   64'(o_cpu_en),   64'd1);

    // Both comparators at 0x40: lowest index wins; 4 enabled cycles from 0x30.
    i_halt_addr = {32'h0000_0040, 32'h0000_0040};
    i_halt_en   = 2'b11;
    i_answer    = 8'hA5;
    i_pc        = 32'h30;
    run_until_stop(50);
    chk("dual_terminal", 64'(o_terminal), 64'd1);
    chk("dual_idx",      64'(o_halt_idx), 64'd0);
    chk("dual_answer",   64'(o_answer),   64'hA5);
    chk("dual_cycles",   64'(o_cycles),   64'd4);

    // Only comparator 1 enabled: index 1 reported.
    i_halt_en = 2'b10;
    i_pc      = 32'h3C;
    i_answer  = 8'h5A;
    start_pulse();
    run_until_stop(50);
    chk("idx1_terminal", 64'(o_terminal), 64'd1);
    chk("idx1_idx",      64'(o_halt_idx), 64'd1);
    chk("idx1_answer",   64'(o_answer),   64'h5A);
    chk("idx1_cycles",   64'(o_cycles),   64'd1);

    // Step mode: 3 single-cycle pulses over 10 cycles, then i_step held 4 cycles.
    i_halt_en   = 2'b00;
    i_pc        = '0;
    i_step_mode = 1'b1;
    start_pulse();
    for (int c = 0; c < 10; c++) begin
      i_step = (c == 1 || c == 4 || c == 7);
      tick();
    end
    i_step = 1'b0;
    chk("step_cycles3", 64'(o_cycles), 64'd3);
    chk("step_pc",      64'(i_pc),     64'd12);
    i_step = 1'b1;
    for (int c = 0; c < 4; c++) tick();
    i_step = 1'b0;
    chk("step_held", 64'(o_cycles), 64'd7);
    start_pulse();
    chk("start_in_run_ignored", 64'(o_cycles), 64'd7);
    chk("step_idle_en",         64'(o_cpu_en), 64'd0);

    // Reset mid-run with a simultaneous start: reset wins.
    i_step_mode = 1'b0;
    rst = 1'b1; i_start = 1'b1;
    tick();
    rst = 1'b0; i_start = 1'b0;
    chk("mrst_cpu_en",   64'(o_cpu_en),   64'd0);
    chk("mrst_terminal", 64'(o_terminal), 64'd0);
    chk("mrst_idx",      64'(o_halt_idx), 64'd0);
    chk("mrst_cycles",   64'(o_cycles),   64'd0);
    chk("mrst_answer",   64'(o_answer),   64'd0);
    tick();
    chk("mrst_idle_en",     64'(o_cpu_en), 64'd0);
    chk("mrst_idle_cycles", 64'(o_cycles), 64'd0);

    // Timeout of 5 without a match.
    i_timeout = 32'd5;
    i_pc      = '0;
    start_pulse();
    for (int c = 0; c < 10; c++) tick();
`ifdef RUN_MONITOR_TIMEOUT_EN
    chk("to_flag",   64'(o_timeout), 64'd1);
    chk("to_cycles", 64'(o_cycles),  64'd5);
    chk("to_cpu_en", 64'(o_cpu_en),  64'd0);
`else
    chk("to_flag_off",   64'(o_timeout), 64'd0);
    chk("to_cycles_off", 64'(o_cycles),  64'd10);
    chk("to_cpu_en_off", 64'(o_cpu_en),  64'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
`endif

    // Match on the fifth cycle beats the timeout.
    i_halt_addr = {32'h0000_0000, 32'h0000_0010};
    i_halt_en   = 2'b01;
    i_pc        = '0;
    i_answer    = 8'h3C;
    start_pulse();
    run_until_stop(50);
    chk("tm_terminal", 64'(o_terminal), 64'd1);
    chk("tm_timeout",  64'(o_timeout),  64'd0);
    chk("tm_cycles",   64'(o_cycles),   64'd4);
    chk("tm_answer",   64'(o_answer),   64'h3C);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
